// File: rtl/sqi_sram_resp_pkg.sv
// Shared definitions for the SQI SRAM responder: FSM states, command
// codes and the nibble count of each transaction phase.
package sqi_sram_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_WRITE  = 3'd4,
    ST_RDATA  = 3'd5,
    ST_IGNORE = 3'd6
  } sqi_state_e;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam logic [2:0] CMD_NIBBLES   = 3'd2;
  localparam logic [2:0] ADDR_NIBBLES  = 3'd6;
  localparam logic [2:0] DUMMY_NIBBLES = 3'd2;

endpackage

// File: rtl/sqi_edge_det.sv
// Registers the SQI pins once into the clk domain and flags sck/cs edges
// by comparing each registered sample against the previous one.
module sqi_edge_det (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sck,
  input  logic       i_cs,
  input  logic [3:0] i_data,
  output logic       o_sck_rise,
  output logic       o_sck_fall,
  output logic       o_cs_fall,
  output logic       o_cs_high,
  output logic [3:0] o_data
);

  logic       r_sck;
  logic       r_sck_prev;
  logic       r_cs;
  logic       r_cs_prev;
  logic [3:0] r_data;

  // Sample the pins; during reset both stages track the pins so that a cs
  // already held low at reset release is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sck      <= i_sck;
      r_sck_prev <= i_sck;
      r_cs       <= i_cs;
      r_cs_prev  <= i_cs;
      r_data     <= 4'h0;
    end else begin
      r_sck      <= i_sck;
      r_sck_prev <= r_sck;
      r_cs       <= i_cs;
      r_cs_prev  <= r_cs;
      r_data     <= i_data;
    end
  end

  assign o_sck_rise = r_sck & ~r_sck_prev;
  assign o_sck_fall = ~r_sck & r_sck_prev;
  assign o_cs_fall  = ~r_cs & r_cs_prev;
  assign o_cs_high  = r_cs;
  assign o_data     = r_data;

endmodule

// File: rtl/sqi_sram_resp.sv
// SQI serial SRAM responder: decodes READ/WRITE commands with a 24-bit
// address from nibble-wide SQI transfers and serves a flop-array memory.
module sqi_sram_resp
  import sqi_sram_resp_pkg::*;
#(
  parameter int         ADDR_W   = 8,
  parameter logic [7:0] MEM_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sqi_sck,
  input  logic       sqi_cs,
  input  logic [3:0] sqi_data_in,
  output logic [3:0] sqi_data_out,
  output logic [3:0] sqi_data_oe,
  output logic       busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              w_sck_rise;
  logic              w_sck_fall;
  logic              w_cs_fall;
  logic              w_cs_high;
  logic [3:0]        w_din;

  sqi_state_e        r_state;
  sqi_state_e        w_state_nxt;
  logic [2:0]        r_cnt,   w_cnt_nxt;
  logic [19:0]       r_shift, w_shift_nxt;
  logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
  logic [3:0]        r_hi,    w_hi_nxt;
  logic              r_lo,    w_lo_nxt;
  logic              r_rd,    w_rd_nxt;
  logic [3:0]        r_out,   w_out_nxt;
  logic [3:0]        r_oe,    w_oe_nxt;
  logic              r_busy;
  logic              w_we;
  logic [7:0]        w_cmd;
  logic [7:0]        w_rbyte;
  logic [7:0]        r_mem [DEPTH];

  sqi_edge_det u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sck      (sqi_sck),
    .i_cs       (sqi_cs),
    .i_data     (sqi_data_in),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_cs_fall  (w_cs_fall),
    .o_cs_high  (w_cs_high),
    .o_data     (w_din)
  );

  assign w_rbyte = r_mem[r_addr];
  assign w_cmd   = {r_shift[3:0], w_din};

  // Next-state and datapath decisions; cs events always win over sck events.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_addr_nxt  = r_addr;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_rd_nxt    = r_rd;
    w_out_nxt   = r_out;
    w_oe_nxt    = r_oe;
    w_we        = 1'b0;
    if (w_cs_fall) begin
      w_state_nxt = ST_CMD;
      w_cnt_nxt   = 3'd0;
      w_lo_nxt    = 1'b0;
      w_oe_nxt    = 4'h0;
    end else if (w_cs_high) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 3'd0;
      w_lo_nxt    = 1'b0;
      w_oe_nxt    = 4'h0;
    end else begin
      case (r_state)
        ST_CMD: begin
          if (w_sck_rise) begin
            w_shift_nxt = {r_shift[15:0], w_din};
            if (r_cnt == CMD_NIBBLES - 3'd1) begin
              w_cnt_nxt = 3'd0;
              if (w_cmd == CMD_READ) begin
                w_state_nxt = ST_ADDR;
                w_rd_nxt    = 1'b1;
              end else if (w_cmd == CMD_WRITE) begin
                w_state_nxt = ST_ADDR;
                w_rd_nxt    = 1'b0;
              end else begin
                w_state_nxt = ST_IGNORE;
              end
            end else begin
              w_cnt_nxt = r_cnt + 3'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        ST_ADDR: begin
          if (w_sck_rise) begin
            w_shift_nxt = {r_shift[15:0], w_din};
            if (r_cnt == ADDR_NIBBLES - 3'd1) begin
              w_cnt_nxt   = 3'd0;
              w_addr_nxt  = ADDR_W'({r_shift, w_din});
              w_lo_nxt    = 1'b0;
              w_state_nxt = r_rd ? ST_DUMMY : ST_WRITE;
            end else begin
              w_cnt_nxt = r_cnt + 3'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        ST_DUMMY: begin
          // Only falls after the final dummy nibble start the read phase.
          if (w_sck_rise && (r_cnt != DUMMY_NIBBLES)) begin
            w_cnt_nxt = r_cnt + 3'd1;
          end else if (w_sck_fall && (r_cnt == DUMMY_NIBBLES)) begin
            w_out_nxt   = w_rbyte[7:4];
            w_oe_nxt    = 4'hF;
            w_lo_nxt    = 1'b1;
            w_state_nxt = ST_RDATA;
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        ST_RDATA: begin
          if (w_sck_fall) begin
            if (r_lo) begin
              w_out_nxt  = w_rbyte[3:0];
              w_addr_nxt = r_addr + ADDR_W'(1);
              w_lo_nxt   = 1'b0;
            end else begin
              w_out_nxt = w_rbyte[7:4];
              w_lo_nxt  = 1'b1;
            end
          end else begin
            w_out_nxt = r_out;
          end
        end
        ST_WRITE: begin
          // The high nibble waits in r_hi; the byte commits on the low nibble.
          if (w_sck_rise) begin
            if (r_lo) begin
              w_we       = 1'b1;
              w_addr_nxt = r_addr + ADDR_W'(1);
              w_lo_nxt   = 1'b0;
            end else begin
              w_hi_nxt = w_din;
              w_lo_nxt = 1'b1;
            end
          end else begin
            w_hi_nxt = r_hi;
          end
        end
        ST_IDLE:   w_state_nxt = ST_IDLE;
        ST_IGNORE: w_state_nxt = ST_IGNORE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered output register bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= 3'd0;
      r_shift <= 20'h0;
      r_addr  <= '0;
      r_hi    <= 4'h0;
      r_lo    <= 1'b0;
      r_rd    <= 1'b0;
      r_out   <= 4'h0;
      r_oe    <= 4'h0;
      r_busy  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_addr  <= w_addr_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_rd    <= w_rd_nxt;
      r_out   <= w_out_nxt;
      r_oe    <= w_oe_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Single-write-port memory array, filled with MEM_INIT at reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= MEM_INIT;
      end
    end else if (w_we) begin
      r_mem[r_addr] <= {r_hi, w_din};
    end
  end

  assign sqi_data_out = r_out;
  assign sqi_data_oe  = r_oe;
  assign busy         = r_busy;

endmodule

// File: tb/tb_sqi_sram_resp.sv
// Self-checking bench for sqi_sram_resp: drives SQI transactions and checks
// read data, oe and busy against a byte-array model of the memory.
module tb_sqi_sram_resp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sqi_sck;
  logic       sqi_cs;
  logic [3:0] sqi_data_in;
  logic [3:0] sqi_data_out;
  logic [3:0] sqi_data_oe;
  logic       busy;

  logic [7:0] mem_model [256];
  int         chk_cnt = 0;
  int         pass_cnt = 0;
  logic [3:0] rd_nibs [$];
  logic [3:0] rd_oes  [$];
  logic       end_busy;
  logic [3:0] end_oe;

  always #5 clk = ~clk;

  sqi_sram_resp #(.ADDR_W(8), .MEM_INIT(8'h00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sqi_sck      (sqi_sck),
    .sqi_cs       (sqi_cs),
    .sqi_data_in  (sqi_data_in),
    .sqi_data_out (sqi_data_out),
    .sqi_data_oe  (sqi_data_oe),
    .busy         (busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [3:0] exp_nib(input logic [23:0] a, input int k);
    logic [7:0] idx;
    logic [7:0] b;
    idx = a[7:0] + 8'(k / 2);
    b   = mem_model[idx];
    return (k % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_nib(input logic [3:0] n);
    sqi_data_in = n;
    sqi_sck     = 1'b0;
    wait_clks(4);
    sqi_sck = 1'b1;
    wait_clks(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
  endtask

  task automatic cs_begin();
    @(negedge clk);
    sqi_sck = 1'b0;
    sqi_cs  = 1'b0;
    wait_clks(4);
  endtask

  task automatic cs_end();
    sqi_cs = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    end_busy = busy;
    end_oe   = sqi_data_oe;
    wait_clks(2);
    sqi_sck = 1'b0;
    wait_clks(4);
  endtask

  task automatic read_nibbles(input int n);
    for (int i = 0; i < n; i++) begin
      sqi_sck = 1'b0;
      wait_clks(4);
      rd_nibs.push_back(sqi_data_out);
      rd_oes.push_back(sqi_data_oe);
      sqi_sck = 1'b1;
      wait_clks(4);
    end
  endtask

  task automatic do_write(input logic [23:0] a, input logic [7:0] data [$]);
    cs_begin();
    send_byte(8'h02);
    send_addr(a);
    foreach (data[i]) send_byte(data[i]);
    cs_end();
    foreach (data[i]) mem_model[a[7:0] + 8'(i)] = data[i];
  endtask

  task automatic do_read(input logic [23:0] a, input int nbytes);
    rd_nibs.delete();
    rd_oes.delete();
    cs_begin();
    send_byte(8'h03);
    send_addr(a);
    send_nib(4'($urandom));
    send_nib(4'($urandom));
    read_nibbles(2 * nbytes);
    cs_end();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sqi_cs = 1'b1; sqi_sck = 1'b0; sqi_data_in = 4'h0;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    wait_clks(5);
    chk_cnt++;
    if ({sqi_data_out, sqi_data_oe, busy} !== 9'h000)
      $display("FAIL reset_outputs: got out=%h oe=%h busy=%b expected 0 0 0", sqi_data_out, sqi_data_oe, busy);
    else pass_cnt++;
    rst_n = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_first_read();
    do_read(24'h000010, 1);
    for (int k = 0; k < 2; k++) begin
      chk_cnt++;
      if (rd_nibs[k] !== exp_nib(24'h000010, k) || rd_nibs[k] !== 4'h0)
        $display("FAIL first_read_nib%0d: got %h expected %h", k, rd_nibs[k], exp_nib(24'h000010, k));
      else pass_cnt++;
      chk_cnt++;
      if (rd_oes[k] !== 4'hF) $display("FAIL first_read_oe%0d: got %h expected f", k, rd_oes[k]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (end_oe !== 4'h0 || end_busy !== 1'b0)
      $display("FAIL first_read_end: got oe=%h busy=%b expected 0 0", end_oe, end_busy);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    logic [7:0] d [$];
    logic [3:0] want [4];
    want[0] = 4'hA; want[1] = 4'h5; want[2] = 4'h3; want[3] = 4'hC;
    d = '{8'hA5, 8'h3C};
    do_write(24'h000020, d);
    do_read(24'h000020, 2);
    for (int k = 0; k < 4; k++) begin
      chk_cnt++;
      if (rd_nibs[k] !== want[k] || rd_nibs[k] !== exp_nib(24'h000020, k))
        $display("FAIL write_read_nib%0d: got %h expected %h", k, rd_nibs[k], want[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d [$];
    d = '{8'h11, 8'h22};
    do_write(24'h0000FF, d);
    do_read(24'h000000, 1);
    chk_cnt++;
    if ({rd_nibs[0], rd_nibs[1]} !== 8'h22 || {rd_nibs[0], rd_nibs[1]} !== mem_model[0])
      $display("FAIL wrap_addr0: got %h%h expected 22", rd_nibs[0], rd_nibs[1]);
    else pass_cnt++;
    do_read(24'h0000FF, 2);
    chk_cnt++;
    if ({rd_nibs[0], rd_nibs[1], rd_nibs[2], rd_nibs[3]} !== 16'h1122)
      $display("FAIL wrap_read_ff: got %h%h%h%h expected 1122", rd_nibs[0], rd_nibs[1], rd_nibs[2], rd_nibs[3]);
    else pass_cnt++;
  endtask

  task automatic test_ignore();
    logic [3:0] oe_seen;
    oe_seen = 4'h0;
    cs_begin();
    send_byte(8'h9F);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL ignore_busy_high: got %b expected 1", busy);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      send_nib(4'($urandom));
      oe_seen = oe_seen | sqi_data_oe;
      sqi_sck = 1'b0;
      wait_clks(4);
      oe_seen = oe_seen | sqi_data_oe;
    end
    sqi_sck = 1'b1;
    wait_clks(4);
    cs_end();
    chk_cnt++;
    if (oe_seen !== 4'h0) $display("FAIL ignore_oe: got %h expected 0", oe_seen);
    else pass_cnt++;
    chk_cnt++;
    if (end_busy !== 1'b0) $display("FAIL ignore_busy_drop: got %b expected 0", end_busy);
    else pass_cnt++;
    do_read(24'h000020, 2);
    for (int k = 0; k < 4; k++) begin
      chk_cnt++;
      if (rd_nibs[k] !== exp_nib(24'h000020, k))
        $display("FAIL ignore_mem_nib%0d: got %h expected %h", k, rd_nibs[k], exp_nib(24'h000020, k));
      else pass_cnt++;
    end
  endtask

  task automatic test_partial_write();
    cs_begin();
    send_byte(8'h02);
    send_addr(24'h000021);
    send_nib(4'h7);
    cs_end();
    do_read(24'h000021, 1);
    chk_cnt++;
    if ({rd_nibs[0], rd_nibs[1]} !== mem_model[8'h21])
      $display("FAIL partial_write: got %h%h expected %h", rd_nibs[0], rd_nibs[1], mem_model[8'h21]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d [$];
    rd_nibs.delete();
    rd_oes.delete();
    cs_begin();
    send_byte(8'h03);
    send_addr(24'h000020);
    send_nib(4'h0);
    send_nib(4'h0);
    read_nibbles(2);
    chk_cnt++;
    if (rd_oes[1] !== 4'hF) $display("FAIL mid_read_oe_before: got %h expected f", rd_oes[1]);
    else pass_cnt++;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (sqi_data_oe !== 4'h0 || busy !== 1'b0)
      $display("FAIL mid_read_reset: got oe=%h busy=%b expected 0 0", sqi_data_oe, busy);
    else pass_cnt++;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    wait_clks(2);
    sqi_cs = 1'b1; sqi_sck = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(4);
    do_read(24'h000020, 1);
    chk_cnt++;
    if ({rd_nibs[0], rd_nibs[1]} !== mem_model[8'h20])
      $display("FAIL post_reset_mem: got %h%h expected %h", rd_nibs[0], rd_nibs[1], mem_model[8'h20]);
    else pass_cnt++;
    d = '{8'($urandom), 8'($urandom), 8'($urandom)};
    do_write(24'h000040, d);
    do_read(24'h000040, 3);
    for (int k = 0; k < 6; k++) begin
      chk_cnt++;
      if (rd_nibs[k] !== exp_nib(24'h000040, k))
        $display("FAIL post_reset_read_nib%0d: got %h expected %h", k, rd_nibs[k], exp_nib(24'h000040, k));
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [7:0]  d [$];
    logic [23:0] a;
    int          n;
    for (int t = 0; t < 6; t++) begin
      d.delete();
      a = 24'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      do_write(a, d);
      a = {8'($urandom), 8'($urandom), a[7:0] + 8'($urandom_range(0, 2))};
      n = $urandom_range(1, 3);
      do_read(a, n);
      for (int k = 0; k < 2 * n; k++) begin
        chk_cnt++;
        if (rd_nibs[k] !== exp_nib(a, k))
          $display("FAIL random_t%0d_nib%0d: got %h expected %h addr %h", t, k, rd_nibs[k], exp_nib(a, k), a);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_write_read();
    test_wrap();
    test_ignore();
    test_partial_write();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sqi_sram_resp.md
SQI_SRAM_RESP -- requirements
Module: sqi_sram_resp

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the internal memory depth to 2**ADDR_W bytes.
REQ-002 Parameter MEM_INIT, default 0, SHALL give the byte value loaded into every location at reset.
REQ-003 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous and active-low.
REQ-005 sqi_sck  input  1  SHALL be the SQI clock from the initiator; it is sampled by clk.
REQ-006 sqi_cs  input  1  SHALL be the active-low chip select.
REQ-007 sqi_data_in  input  4  SHALL carry nibbles from the initiator.
REQ-008 sqi_data_out  output  4  SHALL carry read-data nibbles to the initiator.
REQ-009 sqi_data_oe  output  4  SHALL be all-ones while the responder drives data, otherwise zero.
REQ-010 busy  output  1  SHALL be high while a transaction is in progress.

Function
REQ-011 sqi_sck, sqi_cs and sqi_data_in SHALL be registered once; sck edges SHALL be detected against the previous registered sample.
REQ-012 The initiator holds each sck high/low phase for at least 3 clk cycles; the block SHALL be correct at that rate.
REQ-013 While cs is high, states: IDLE; cs falling SHALL enter CMD with nibble counter 0.
REQ-014 Each sck rising edge in CMD/ADDR/DUMMY/WRITE SHALL sample one nibble, high nibble first.
REQ-015 CMD SHALL take 2 nibbles; 0x03 = READ, 0x02 = WRITE; any other value SHALL enter IGNORE until cs high.
REQ-016 ADDR SHALL take 6 nibbles (24-bit address); only the low ADDR_W bits are used; upper bits are ignored.
REQ-017 READ SHALL pass through DUMMY for 2 nibbles (one dummy byte); sampled values are discarded.
REQ-018 On the first sck falling edge after the last dummy nibble, the block SHALL drive the high nibble of mem[addr], set sqi_data_oe=4'hF, and enter RDATA.
REQ-019 In RDATA, each later sck falling edge SHALL advance to the next nibble; after a low nibble, addr SHALL increment.
REQ-020 sqi_data_out SHALL change no later than 2 clk cycles after sck falling at the pins.
REQ-021 In WRITE, the high nibble SHALL be held; on the low-nibble rising edge, mem[addr] SHALL be written and addr SHALL increment.
REQ-022 The address SHALL wrap from 2**ADDR_W-1 to 0 for both read and write.
REQ-023 cs rising in any state SHALL return to IDLE within 2 clk cycles and set sqi_data_oe=0.
REQ-024 On cs rising, a partially received write byte SHALL be discarded and memory left unchanged.
REQ-025 A cs edge and an sck edge detected in the same cycle SHALL resolve with cs taking priority.
REQ-026 busy SHALL be high from cs-low detection until IDLE is re-entered.

Reset
REQ-027 While rst_n is low at a clk edge, the block SHALL enter IDLE and clear the nibble counter and address.
REQ-028 Reset SHALL drive sqi_data_out=0, sqi_data_oe=0 and busy=0.
REQ-029 Reset SHALL load every memory byte with MEM_INIT.
REQ-030 Reset asserted mid-transaction SHALL abort it; after release, the block SHALL wait for a fresh cs falling edge.

Structure
REQ-031 A shared package SHALL hold the state enumeration, the command codes READ=8'h03 and WRITE=8'h02, and the nibble counts CMD=2, ADDR=6, DUMMY=2.
REQ-032 Edge detection (input register plus previous-sample compare) SHALL be a sub-module named sqi_edge_det.
REQ-033 Memory SHALL be a flop array inside sqi_sram_resp with one write port and one read port.

Verification
REQ-034 After reset, read addr 0x000010 for 1 byte -> data_out 0x0 then 0x0 (MEM_INIT=0); oe=0 after cs high.
REQ-035 Write 0xA5,0x3C at 0x000020, then read 2 bytes at 0x000020 -> nibbles A,5,3,C.
REQ-036 With ADDR_W=8, write 0x11,0x22 at 0x0000FF, then read at 0x000000 -> 0x22, and read at 0x0000FF -> 0x11.
REQ-037 Send command 0x9F followed by 8 nibbles -> oe stays 0 and memory is unchanged; busy drops within 2 clk after cs high.
REQ-038 Write high nibble 0x7 only, then raise cs -> a later read of that address returns the prior value.
REQ-039 Assert rst_n low mid-RDATA -> oe=0 and busy=0 on the next clk; a subsequent full read succeeds.
